// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/trap/mret redirects, stall, halt/resume and misaligned-target trapping.
module pc_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'('h0000_1000),
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'('h0000_0100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap,
  input  logic            mret,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc_out,
  output logic            misaligned,
  output logic            halted
);
  typedef enum logic [1:0] {S_RESET, S_RUN, S_HALT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d, target;
  logic mis_q, mis_d, redirect, bad;
  assign pc_out = pc_q;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign epc_out = epc_q;
  assign misaligned = mis_q;
  assign pc_valid = state_q == S_RUN;
  assign halted = state_q == S_HALT;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    epc_d = epc_q;
    mis_d = 1'b0;
    target = mret ? epc_q : jump ? jump_target : branch_target;
    redirect = mret | jump | branch_taken;
    bad = redirect && target[1:0] != 2'b00;
    if (state_q == S_RESET) begin
      state_d = S_RUN;
    end else if (state_q == S_HALT) begin
      if (trap) begin
        state_d = S_RUN;
        pc_d = TRAP_VECTOR;
        epc_d = pc_q;
      end else if (resume) begin
        state_d = S_RUN;
      end
    end else if (trap || bad) begin
      pc_d = TRAP_VECTOR;
      epc_d = pc_q;
      mis_d = !trap;
    end else if (redirect) begin
      pc_d = target;
    end else if (halt) begin
      state_d = S_HALT;
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      pc_q <= RESET_VECTOR;
      epc_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit; a spec-level model queues expected outputs, a monitor pops and compares each cycle.
module tb_pc_unit;
  logic clk = 1'b0;
  logic reset, stall, branch_taken, jump, trap, mret, halt, resume;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc_out, pc_plus4, epc_out;
  logic pc_valid, misaligned, halted;
  always #5 clk = ~clk;
  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .trap(trap), .mret(mret), .halt(halt), .resume(resume),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .pc_valid(pc_valid),
    .epc_out(epc_out), .misaligned(misaligned), .halted(halted)
  );
  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic valid;
    logic mis;
    logic hlt;
  } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  // Reference model: "running" and "sleeping" flags; neither set means just out of reset.
  logic [31:0] m_pc, m_epc;
  bit m_running, m_sleeping, m_mis;
  task automatic model_edge();
    logic [31:0] tgt;
    bit any;
    m_mis = 0;
    any = mret || jump || branch_taken;
    tgt = mret ? m_epc : (jump ? jump_target : branch_target);
    if (reset) begin
      m_pc = 32'h1000; m_epc = 0; m_running = 0; m_sleeping = 0;
    end else if (!m_running && !m_sleeping) begin
      m_running = 1;
    end else if (m_sleeping) begin
      if (trap) begin
        m_epc = m_pc; m_pc = 32'h100; m_sleeping = 0; m_running = 1;
      end else if (resume) begin
        m_sleeping = 0; m_running = 1;
      end
    end else if (trap) begin
      m_epc = m_pc; m_pc = 32'h100;
    end else if (any && (tgt % 4) != 0) begin
      m_epc = m_pc; m_pc = 32'h100; m_mis = 1;
    end else if (any) begin
      m_pc = tgt;
    end else if (halt) begin
      m_running = 0; m_sleeping = 1;
    end else if (!stall) begin
      m_pc = m_pc + 4;
    end
  endtask
  task automatic tick();
    model_edge();
    sb.push_back('{pc: m_pc, epc: m_epc, valid: m_running, mis: m_mis, hlt: m_sleeping});
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic clr();
    reset = 0; stall = 0; branch_taken = 0; jump = 0; trap = 0; mret = 0; halt = 0; resume = 0;
    branch_target = 0; jump_target = 0;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc_out", pc_out, e.pc);
      chk("pc_plus4", pc_plus4, e.pc + 32'd4);
      chk("epc_out", epc_out, e.epc);
      chk("pc_valid", 32'(pc_valid), 32'(e.valid));
      chk("misaligned", 32'(misaligned), 32'(e.mis));
      chk("halted", 32'(halted), 32'(e.hlt));
    end
  end
  function automatic logic [31:0] rnd_target();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(7) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
    if ($urandom_range(3) != 0) r[1:0] = 2'b00;
    return r;
  endfunction
  initial begin
    clr();
    reset = 1;
    @(negedge clk);
    tick(); tick();
    reset = 0;
    repeat (5) tick();
    branch_taken = 1; branch_target = 32'h2000; jump = 1; jump_target = 32'h3000; stall = 1;
    tick();
    clr(); trap = 1; jump = 1; jump_target = 32'h4000;
    tick();
    clr(); jump = 1; jump_target = 32'h1020;
    tick();
    jump_target = 32'h1042;
    tick();
    clr(); mret = 1;
    tick();
    clr(); jump = 1; jump_target = 32'h1004;
    tick();
    clr(); stall = 1;
    repeat (3) tick();
    clr(); halt = 1;
    tick();
    clr(); jump = 1; jump_target = 32'h5000; stall = 1; mret = 1;
    tick();
    clr(); resume = 1;
    tick();
    clr();
    tick(); tick();
    jump = 1; jump_target = 32'hFFFF_FFFC;
    tick();
    clr();
    tick(); tick();
    trap = 1; reset = 1;
    tick();
    clr();
    tick(); tick();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(63) == 0);
      trap = ($urandom_range(15) == 0);
      mret = ($urandom_range(15) == 0);
      jump = ($urandom_range(7) == 0);
      branch_taken = ($urandom_range(7) == 0);
      halt = ($urandom_range(15) == 0);
      resume = ($urandom_range(3) == 0);
      stall = ($urandom_range(3) == 0);
      jump_target = rnd_target();
      branch_target = rnd_target();
      tick();
    end
    clr();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
